vend_sequencer: RTL
===================

// Module: vend_sequencer
// PURPOSE
//  Transaction sequencer for the vending machine: accumulates credit from coin pulses, arbitrates
//  product/refund/refill requests, tracks per-product stock, and meters change out one coin at a time.
//  Sits between signal_decoder (single-cycle request pulses) and the display/dispense logic in control.
// PARAMETERS
//  PRICE_COLA   5   coca_cola price, half-yuan units (2.5 yuan)
//  PRICE_OOLONG 4   oolong price, half-yuan units
//  PRICE_TEA    3   redtea price, half-yuan units
//  CREDIT_MAX   20  credit ceiling, half-yuan units (10 yuan); must fit 5 bits
//  STOCK_MAX    9   stock level loaded by fill_up; must fit 4 bits
//  CHANGE_GAP   4   clk cycles between successive change_pulse (>=2)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous active-high reset
//  wu_jiao       in   1  0.5-yuan coin pulse (1 cycle)
//  yi_yuan       in   1  1-yuan coin pulse (1 cycle)
//  coca_cola     in   1  select cola pulse
//  oolong        in   1  select oolong pulse
//  redtea        in   1  select redtea pulse
//  coin_out      in   1  refund request pulse
//  fill_up       in   1  restock request pulse
//  credit        out  5  current credit, half-yuan units
//  vend_valid    out  1  1-cycle dispense strobe
//  vend_item     out  2  item dispensed: 1 cola, 2 oolong, 3 redtea; 0 when vend_valid low
//  change_pulse  out  1  1-cycle strobe = return one 0.5-yuan coin
//  coin_reject   out  1  1-cycle strobe: inserted coin not accepted, return it
//  err_soldout   out  1  1-cycle strobe: selected item stock is 0
//  err_funds     out  1  1-cycle strobe: credit < price of selected item
//  busy          out  1  high in VEND and CHANGE
//  stock_cola/stock_oolong/stock_redtea  out 4 each  current stock levels
// BEHAVIOUR
//  - Reset: state IDLE, credit 0, all stocks STOCK_MAX, gap counter 0, all strobes 0, vend_item 0.
//  - All strobes are registered: asserted the cycle after the causing input/state, exactly 1 cycle.
//  - States: IDLE, VEND, CHANGE. busy = (state != IDLE).
//  - IDLE, per cycle, one action by priority: fill_up > coin_out > select > coin.
//    fill_up: all stocks <= STOCK_MAX; credit unchanged; any coproduced coin -> coin_reject.
//    coin_out: credit>0 -> CHANGE, gap counter cleared; credit==0 -> no-op.
//    select (multiple same cycle: cola > oolong > redtea): stock==0 -> err_soldout;
//      else credit<price -> err_funds; else credit-=price, stock-=1, -> VEND. Soldout checked first.
//    coin (wu_jiao +1, yi_yuan +2; both same cycle = +3): if credit+value > CREDIT_MAX the whole
//      insertion is refused (coin_reject, credit unchanged); else credit += value.
//    Any coin pulse losing arbitration to coin_out or select -> coin_reject; credit unchanged.
//  - VEND (1 cycle): vend_valid=1, vend_item set; next CHANGE if credit>0 else IDLE.
//  - CHANGE: first change_pulse on entry cycle+1, then every CHANGE_GAP cycles; each pulse credit-=1;
//    when credit reaches 0 return to IDLE same cycle as last pulse. Exactly credit pulses total.
//  - VEND/CHANGE: coins -> coin_reject; selects, coin_out, fill_up ignored (no strobes).
//  - Width: credit never exceeds CREDIT_MAX nor underflows; stock never underflows (guarded by soldout).
//  - rst mid-CHANGE: remaining credit discarded, no further change_pulse, stocks reloaded.
// TESTING
//  1. rst; yi_yuan x3 (credit 6), coca_cola -> vend_valid, vend_item=1, credit 1, 1 change_pulse, stock_cola 8, IDLE.
//  2. credit 3, oolong -> err_funds, credit stays 3; then coin_out -> 3 change_pulse CHANGE_GAP apart, credit 0.
//  3. Drain redtea to 0 stock, select redtea with credit 6 -> err_soldout; fill_up -> stock_redtea 9.
//  4. credit 19, yi_yuan -> coin_reject, credit 19; wu_jiao -> credit 20; wu_jiao+yi_yuan same cycle at credit 0 -> 3.
//  5. credit 8, coca_cola+redtea+wu_jiao same cycle -> cola vended, coin_reject, credit 3; coins during CHANGE -> coin_reject.
//  6. rst asserted during CHANGE with credit 4 -> next cycle credit 0, IDLE, no change_pulse, stocks 9.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: credit accumulation, request arbitration, per-item stock, metered change.
// All strobes are registered one cycle after their cause; coins outside an accepted IDLE insertion are rejected.
module vend_sequencer #(
   parameter int PRICE_COLA   = 5,
   parameter int PRICE_OOLONG = 4,
   parameter int PRICE_TEA    = 3,
   parameter int CREDIT_MAX   = 20,
   parameter int STOCK_MAX    = 9,
   parameter int CHANGE_GAP   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wu_jiao,
   input  logic       yi_yuan,
   input  logic       coca_cola,
   input  logic       oolong,
   input  logic       redtea,
   input  logic       coin_out,
   input  logic       fill_up,
   output logic [4:0] credit,
   output logic       vend_valid,
   output logic [1:0] vend_item,
   output logic       change_pulse,
   output logic       coin_reject,
   output logic       err_soldout,
   output logic       err_funds,
   output logic       busy,
   output logic [3:0] stock_cola,
   output logic [3:0] stock_oolong,
   output logic [3:0] stock_redtea
);

   localparam int GW = $clog2(CHANGE_GAP);
   localparam logic [GW-1:0] GAP_RELOAD = GW'(CHANGE_GAP - 1);
   localparam logic [5:0]    CMAX       = 6'(CREDIT_MAX);
   localparam logic [3:0]    SMAX       = 4'(STOCK_MAX);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   state_t        state, state_nx;
   logic [4:0]    credit_nx;
   logic [3:0]    stock_cola_nx, stock_oolong_nx, stock_redtea_nx;
   logic [GW-1:0] gap_cnt, gap_nx;
   logic          vend_valid_nx, change_nx, reject_nx, soldout_nx, funds_nx;
   logic [1:0]    vend_item_nx;

   logic [1:0] coin_val;
   logic       coin_any, sel_any;
   logic [1:0] sel_item;
   logic [4:0] sel_price;
   logic [3:0] sel_stock;
   logic [5:0] coin_sum;

   // Coin value in half-yuan units falls straight out of the pulse pair.
   assign coin_val = {yi_yuan, wu_jiao};
   assign coin_any = |coin_val;
   assign sel_any  = coca_cola | oolong | redtea;
   assign coin_sum = {1'b0, credit} + {4'b0, coin_val};
   assign busy     = (state != IDLE);

   always_comb begin
      sel_item  = 2'd3;
      sel_price = 5'(PRICE_TEA);
      sel_stock = stock_redtea;
      if (coca_cola) begin
         sel_item  = 2'd1;
         sel_price = 5'(PRICE_COLA);
         sel_stock = stock_cola;
      end else if (oolong) begin
         sel_item  = 2'd2;
         sel_price = 5'(PRICE_OOLONG);
         sel_stock = stock_oolong;
      end
   end

   always_comb begin
      state_nx        = state;
      credit_nx       = credit;
      stock_cola_nx   = stock_cola;
      stock_oolong_nx = stock_oolong;
      stock_redtea_nx = stock_redtea;
      gap_nx          = gap_cnt;
      vend_valid_nx   = 1'b0;
      vend_item_nx    = 2'd0;
      change_nx       = 1'b0;
      reject_nx       = 1'b0;
      soldout_nx      = 1'b0;
      funds_nx        = 1'b0;
      unique case (state)
         IDLE: begin
            if (fill_up) begin
               stock_cola_nx   = SMAX;
               stock_oolong_nx = SMAX;
               stock_redtea_nx = SMAX;
               reject_nx       = coin_any;
            end else if (coin_out) begin
               reject_nx = coin_any;
               if (credit != 5'd0) begin
                  state_nx = CHANGE;
                  gap_nx   = '0;
               end
            end else if (sel_any) begin
               reject_nx = coin_any;
               if (sel_stock == 4'd0) begin
                  soldout_nx = 1'b1;
               end else if (credit < sel_price) begin
                  funds_nx = 1'b1;
               end else begin
                  credit_nx     = credit - sel_price;
                  state_nx      = VEND;
                  vend_valid_nx = 1'b1;
                  vend_item_nx  = sel_item;
                  unique case (sel_item)
                     2'd1:    stock_cola_nx   = stock_cola - 4'd1;
                     2'd2:    stock_oolong_nx = stock_oolong - 4'd1;
                     default: stock_redtea_nx = stock_redtea - 4'd1;
                  endcase
               end
            end else if (coin_any) begin
               if (coin_sum > CMAX) reject_nx = 1'b1;
               else                 credit_nx = coin_sum[4:0];
            end
         end
         VEND: begin
            reject_nx = coin_any;
            gap_nx    = '0;
            state_nx  = (credit != 5'd0) ? CHANGE : IDLE;
         end
         CHANGE: begin
            reject_nx = coin_any;
            if (credit == 5'd0) begin
               state_nx = IDLE;
            end else if (gap_cnt == '0) begin
               change_nx = 1'b1;
               credit_nx = credit - 5'd1;
               gap_nx    = GAP_RELOAD;
               if (credit == 5'd1) state_nx = IDLE;
            end else begin
               gap_nx = gap_cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         credit       <= 5'd0;
         stock_cola   <= SMAX;
         stock_oolong <= SMAX;
         stock_redtea <= SMAX;
         gap_cnt      <= '0;
         vend_valid   <= 1'b0;
         vend_item    <= 2'd0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         err_soldout  <= 1'b0;
         err_funds    <= 1'b0;
      end else begin
         state        <= state_nx;
         credit       <= credit_nx;
         stock_cola   <= stock_cola_nx;
         stock_oolong <= stock_oolong_nx;
         stock_redtea <= stock_redtea_nx;
         gap_cnt      <= gap_nx;
         vend_valid   <= vend_valid_nx;
         vend_item    <= vend_item_nx;
         change_pulse <= change_nx;
         coin_reject  <= reject_nx;
         err_soldout  <= soldout_nx;
         err_funds    <= funds_nx;
      end
   end

endmodule
